// File: rtl/memarb.sv
// memarb: shares one external memory port between the cpu and dma requesters.
// Define MEMARB_RR_EN for round-robin arbitration; the default is fixed cpu-over-dma.
module memarb #(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpureq,
  input  logic        cpuwr,
  input  logic [21:0] cpuaddr,
  input  logic [15:0] cpuwdata,
  output logic        cpuack,
  output logic        cpuerr,
  output logic [15:0] cpurdata,
  input  logic        dmareq,
  input  logic        dmawr,
  input  logic [21:0] dmaaddr,
  input  logic [15:0] dmawdata,
  output logic        dmaack,
  output logic        dmaerr,
  output logic [15:0] dmardata,
  output logic        memreq,
  output logic        memwr,
  output logic [21:0] memaddr,
  output logic [15:0] memwdata,
  input  logic        memack,
  input  logic [15:0] memrdata,
  output logic        busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  localparam logic [CNTW-1:0] TO_C = CNTW'(TIMEOUT);

  state_t state_q, state_d;

  logic        cpu_pend_q, cpu_pend_d;
  logic        cpu_wr_q, cpu_wr_d;
  logic [21:0] cpu_addr_q, cpu_addr_d;
  logic [15:0] cpu_wdata_q, cpu_wdata_d;

  logic        dma_pend_q, dma_pend_d;
  logic        dma_wr_q, dma_wr_d;
  logic [21:0] dma_addr_q, dma_addr_d;
  logic [15:0] dma_wdata_q, dma_wdata_d;

  logic            owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic        memreq_q, memreq_d;
  logic        memwr_q, memwr_d;
  logic [21:0] memaddr_q, memaddr_d;
  logic [15:0] memwdata_q, memwdata_d;

  logic        cpuack_q, cpuack_d;
  logic        cpuerr_q, cpuerr_d;
  logic [15:0] cpurdata_q, cpurdata_d;
  logic        dmaack_q, dmaack_d;
  logic        dmaerr_q, dmaerr_d;
  logic [15:0] dmardata_q, dmardata_d;

  logic            cpu_cap, dma_cap;
  logic            any_pend, grant_dma;
  logic            start, done_ack, done_to, done;
  logic [CNTW-1:0] cnt_nxt;
  logic            hit_to;

`ifdef MEMARB_RR_EN
  logic last_q, last_d;
`endif

  assign cpu_cap  = cpureq && !cpu_pend_q;
  assign dma_cap  = dmareq && !dma_pend_q;
  assign any_pend = cpu_pend_q || dma_pend_q;

`ifdef MEMARB_RR_EN
  // With both pending, the port that did not win last time goes next.
  assign grant_dma = dma_pend_q && (!cpu_pend_q || (last_q == OWN_CPU));
`else
  assign grant_dma = !cpu_pend_q;
`endif

  // The counter reaches TIMEOUT on the edge where this comparison holds.
  assign cnt_nxt  = cnt_q + CNTW'(1);
  assign hit_to   = (cnt_nxt == TO_C);
  assign start    = (state_q == S_IDLE) && any_pend;
  assign done_ack = (state_q == S_WAIT) && memack;
  assign done_to  = (state_q == S_WAIT) && !memack && hit_to;
  assign done     = done_ack || done_to;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_pend) state_d = S_WAIT;
      S_WAIT: if (memack || hit_to) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT);

    memreq_d   = start;
    memwr_d    = memwr_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    owner_d    = owner_q;
    if (start) begin
      owner_d    = grant_dma;
      memwr_d    = grant_dma ? dma_wr_q    : cpu_wr_q;
      memaddr_d  = grant_dma ? dma_addr_q  : cpu_addr_q;
      memwdata_d = grant_dma ? dma_wdata_q : cpu_wdata_q;
    end

    cpuack_d   = done && (owner_q == OWN_CPU);
    cpuerr_d   = done_to && (owner_q == OWN_CPU);
    cpurdata_d = (done_ack && (owner_q == OWN_CPU)) ? memrdata : cpurdata_q;
    dmaack_d   = done && (owner_q == OWN_DMA);
    dmaerr_d   = done_to && (owner_q == OWN_DMA);
    dmardata_d = (done_ack && (owner_q == OWN_DMA)) ? memrdata : dmardata_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_nxt;
    end
  end

  // Capture and completion never touch the same port on one edge: capture
  // needs the flag clear, completion needs it set.
  always_comb begin
    cpu_pend_d  = cpu_pend_q;
    cpu_wr_d    = cpu_wr_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    if (cpu_cap) begin
      cpu_pend_d  = 1'b1;
      cpu_wr_d    = cpuwr;
      cpu_addr_d  = cpuaddr;
      cpu_wdata_d = cpuwdata;
    end else if (done && (owner_q == OWN_CPU)) begin
      cpu_pend_d = 1'b0;
    end

    dma_pend_d  = dma_pend_q;
    dma_wr_d    = dma_wr_q;
    dma_addr_d  = dma_addr_q;
    dma_wdata_d = dma_wdata_q;
    if (dma_cap) begin
      dma_pend_d  = 1'b1;
      dma_wr_d    = dmawr;
      dma_addr_d  = dmaaddr;
      dma_wdata_d = dmawdata;
    end else if (done && (owner_q == OWN_DMA)) begin
      dma_pend_d = 1'b0;
    end
  end

`ifdef MEMARB_RR_EN
  assign last_d = start ? grant_dma : last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= OWN_DMA;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_pend_q  <= 1'b0;
      cpu_wr_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      dma_pend_q  <= 1'b0;
      dma_wr_q    <= 1'b0;
      dma_addr_q  <= '0;
      dma_wdata_q <= '0;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
    end else begin
      cpu_pend_q  <= cpu_pend_d;
      cpu_wr_q    <= cpu_wr_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      dma_pend_q  <= dma_pend_d;
      dma_wr_q    <= dma_wr_d;
      dma_addr_q  <= dma_addr_d;
      dma_wdata_q <= dma_wdata_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memreq_q   <= 1'b0;
      memwr_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      cpuack_q   <= 1'b0;
      cpuerr_q   <= 1'b0;
      cpurdata_q <= '0;
      dmaack_q   <= 1'b0;
      dmaerr_q   <= 1'b0;
      dmardata_q <= '0;
    end else begin
      memreq_q   <= memreq_d;
      memwr_q    <= memwr_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      cpuack_q   <= cpuack_d;
      cpuerr_q   <= cpuerr_d;
      cpurdata_q <= cpurdata_d;
      dmaack_q   <= dmaack_d;
      dmaerr_q   <= dmaerr_d;
      dmardata_q <= dmardata_d;
    end
  end

  assign memreq   = memreq_q;
  assign memwr    = memwr_q;
  assign memaddr  = memaddr_q;
  assign memwdata = memwdata_q;
  assign cpuack   = cpuack_q;
  assign cpuerr   = cpuerr_q;
  assign cpurdata = cpurdata_q;
  assign dmaack   = dmaack_q;
  assign dmaerr   = dmaerr_q;
  assign dmardata = dmardata_q;

endmodule

// File: tb/tb_memarb.sv
// Testbench for memarb: directed scenarios plus random traffic against a
// transaction-level reference model (honours MEMARB_RR_EN when defined).
module tb_memarb;
  localparam int TO = 4;

  logic        clk, rstn;
  logic        cpureq, cpuwr, cpuack, cpuerr;
  logic [21:0] cpuaddr;
  logic [15:0] cpuwdata, cpurdata;
  logic        dmareq, dmawr, dmaack, dmaerr;
  logic [21:0] dmaaddr;
  logic [15:0] dmawdata, dmardata;
  logic        memreq, memwr, memack, busy;
  logic [21:0] memaddr;
  logic [15:0] memwdata, memrdata;

  memarb #(.TIMEOUT(TO), .CNTW(16)) dut (
    .clk(clk), .rstn(rstn),
    .cpureq(cpureq), .cpuwr(cpuwr), .cpuaddr(cpuaddr), .cpuwdata(cpuwdata),
    .cpuack(cpuack), .cpuerr(cpuerr), .cpurdata(cpurdata),
    .dmareq(dmareq), .dmawr(dmawr), .dmaaddr(dmaaddr), .dmawdata(dmawdata),
    .dmaack(dmaack), .dmaerr(dmaerr), .dmardata(dmardata),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
    .memack(memack), .memrdata(memrdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: pending requests, one in-flight transaction and its age.
  bit          m_pc, m_pd, m_cw, m_dw, m_busy, m_own, m_last;
  logic [21:0] m_ca, m_da;
  logic [15:0] m_cwd, m_dwd;
  int          m_age;
  logic        e_memreq, e_memwr, e_cack, e_cerr, e_dack, e_derr;
  logic [21:0] e_memaddr;
  logic [15:0] e_memwdata, e_crd, e_drd;

  int          n_memreq, n_cack, n_dack;
  int          t_mreq, t_dack;
  logic        last_derr;
  logic [21:0] last_mreq_addr;
  bit          ack_log[$];

  int          ack_cd  = -1;
  int          ack_dly = 2;
  bit          rand_mode = 0;
  bit          use_fixed = 0;
  logic [15:0] fixed_rd  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pd = 0; m_cw = 0; m_dw = 0; m_busy = 0; m_own = 0; m_last = 1;
    m_ca = '0; m_da = '0; m_cwd = '0; m_dwd = '0; m_age = 0;
    e_memreq = 0; e_memwr = 0; e_memaddr = '0; e_memwdata = '0;
    e_cack = 0; e_cerr = 0; e_crd = '0; e_dack = 0; e_derr = 0; e_drd = '0;
  endtask

  task automatic model_edge();
    bit cap_c, cap_d, own;
    cap_c = cpureq && !m_pc;
    cap_d = dmareq && !m_pd;
    e_memreq = 0; e_cack = 0; e_cerr = 0; e_dack = 0; e_derr = 0;
    if (m_busy) begin
      m_age++;
      if (memack || m_age == TO) begin
        if (m_own == 0) begin
          e_cack = 1; e_cerr = !memack; m_pc = 0;
          if (memack) e_crd = memrdata;
        end else begin
          e_dack = 1; e_derr = !memack; m_pd = 0;
          if (memack) e_drd = memrdata;
        end
        m_busy = 0;
      end
    end else if (m_pc || m_pd) begin
`ifdef MEMARB_RR_EN
      own = (m_pc && m_pd) ? !m_last : m_pd;
`else
      own = !m_pc;
`endif
      m_last = own;
      m_own = own;
      e_memreq = 1;
      e_memwr = own ? m_dw : m_cw;
      e_memaddr = own ? m_da : m_ca;
      e_memwdata = own ? m_dwd : m_cwd;
      m_busy = 1;
      m_age = 0;
    end
    if (cap_c) begin m_pc = 1; m_cw = cpuwr; m_ca = cpuaddr; m_cwd = cpuwdata; end
    if (cap_d) begin m_pd = 1; m_dw = dmawr; m_da = dmaaddr; m_dwd = dmawdata; end
  endtask

  task automatic compare_all();
    check("mem", 64'({memreq, memwr, memaddr, memwdata}),
          64'({e_memreq, e_memwr, e_memaddr, e_memwdata}));
    check("cpu", 64'({cpuack, cpuerr, cpurdata}), 64'({e_cack, e_cerr, e_crd}));
    check("dma", 64'({dmaack, dmaerr, dmardata}), 64'({e_dack, e_derr, e_drd}));
    check("busy", 64'(busy), 64'(m_busy));
    if (memreq) begin n_memreq++; t_mreq = cyc; last_mreq_addr = memaddr; end
    if (cpuack) begin n_cack++; ack_log.push_back(1'b0); end
    if (dmaack) begin n_dack++; ack_log.push_back(1'b1); t_dack = cyc; last_derr = dmaerr; end
  endtask

  task automatic responder();
    if (memreq) begin
      if (rand_mode) begin
        int r;
        r = int'($urandom_range(0, 7));
        ack_cd = (r == 7) ? -1 : r;
      end else begin
        ack_cd = ack_dly;
      end
    end
    memack = (ack_cd == 0);
    if (rand_mode && $urandom_range(0, 19) == 0) memack = 1'b1;
    if (ack_cd >= 0) ack_cd--;
    memrdata = use_fixed ? fixed_rd : 16'($urandom);
  endtask

  task automatic tick(input logic cr, input logic cw, input logic [21:0] ca, input logic [15:0] cwd,
                      input logic dr, input logic dw, input logic [21:0] da, input logic [15:0] dwd);
    cpureq = cr; cpuwr = cw; cpuaddr = ca; cpuwdata = cwd;
    dmareq = dr; dmawr = dw; dmaaddr = da; dmawdata = dwd;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
    responder();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic apply_reset();
    #2;
    rstn = 1'b0;
    memack = 1'b0; ack_cd = -1;
    cpureq = 0; dmareq = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rstn = 1'b1;
  endtask

  initial begin
    int b_mreq, b_cack, b_dack, guard;
    bit rc, rd;
    cpureq = 0; cpuwr = 0; cpuaddr = '0; cpuwdata = '0;
    dmareq = 0; dmawr = 0; dmaaddr = '0; dmawdata = '0;
    memack = 0; memrdata = '0;
    n_memreq = 0; n_cack = 0; n_dack = 0; t_mreq = 0; t_dack = 0;
    last_derr = 0; last_mreq_addr = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rstn = 1'b1;

    // CPU read
    use_fixed = 1; fixed_rd = 16'o123456; ack_dly = 3;
    b_mreq = n_memreq; b_cack = n_cack; b_dack = n_dack;
    tick(1, 0, 22'o1000, 16'h0, 0, 0, '0, '0);
    idle(8);
    check("rd_memreq_cnt", 64'(n_memreq - b_mreq), 1);
    check("rd_addr", 64'(last_mreq_addr), 64'(22'o1000));
    check("rd_cack_cnt", 64'(n_cack - b_cack), 1);
    check("rd_dack_cnt", 64'(n_dack - b_dack), 0);
    check("rd_rdata", 64'(cpurdata), 64'(16'o123456));

    // Simultaneous requests
    use_fixed = 0; ack_dly = 1;
    ack_log.delete();
    b_mreq = n_memreq;
    tick(1, 1, 22'o2000, 16'h00ff, 1, 0, 22'o4000, 16'h0);
    idle(12);
    check("sim_memreq_cnt", 64'(n_memreq - b_mreq), 2);
    check("sim_ack_cnt", 64'(ack_log.size()), 2);
    if (ack_log.size() == 2) begin
      check("sim_first", 64'(ack_log[0]), 0);
      check("sim_second", 64'(ack_log[1]), 1);
    end

    // Both ports re-request immediately after each ack: grants alternate
    ack_log.delete();
    rc = 1; rd = 1; guard = 0;
    while (ack_log.size() < 6 && guard < 100) begin
      tick(rc, 1'b0, 22'(guard), 16'(guard), rd, 1'b1, 22'(guard + 100), 16'hA5A5);
      rc = cpuack; rd = dmaack;
      guard++;
    end
    check("alt_done", 64'(ack_log.size() >= 6), 1);
    for (int k = 0; k < 6 && k < ack_log.size(); k++)
      check($sformatf("alt_grant%0d", k), 64'(ack_log[k]), 64'(k % 2));
    idle(15);

    // Timeout: known dma rdata first, then a read that never gets memack
    use_fixed = 1; fixed_rd = 16'hBEEF; ack_dly = 2;
    tick(0, 0, '0, '0, 1, 0, 22'o1234, '0);
    idle(6);
    use_fixed = 0; ack_dly = -1;
    b_dack = n_dack;
    tick(0, 0, '0, '0, 1, 0, 22'o5670, '0);
    guard = 0;
    while (n_dack == b_dack && guard < 20) begin idle(1); guard++; end
    check("to_seen", 64'(n_dack - b_dack), 1);
    check("to_latency", 64'(t_dack - t_mreq), 64'(TO));
    check("to_err", 64'(last_derr), 1);
    check("to_rdata", 64'(dmardata), 64'(16'hBEEF));
    check("to_busy", 64'(busy), 0);
    idle(1);
    memack = 1'b1;
    b_cack = n_cack;
    idle(4);
    check("late_ack_ign", 64'((n_dack - b_dack) + (n_cack - b_cack)), 1);
    check("late_rdata", 64'(dmardata), 64'(16'hBEEF));

    // Duplicate pulse while cpu pending
    ack_dly = 3;
    b_mreq = n_memreq; b_cack = n_cack;
    tick(1, 0, 22'o0100, '0, 0, 0, '0, '0);
    tick(1, 0, 22'o7777, '0, 0, 0, '0, '0);
    idle(10);
    check("dup_addr", 64'(last_mreq_addr), 64'(22'o0100));
    check("dup_memreq_cnt", 64'(n_memreq - b_mreq), 1);
    check("dup_cack_cnt", 64'(n_cack - b_cack), 1);

    // Reset mid-WAIT
    ack_dly = -1;
    tick(1, 0, 22'o3000, '0, 0, 0, '0, '0);
    idle(3);
    check("rst_in_wait", 64'(busy), 1);
    apply_reset();
    b_cack = n_cack; b_dack = n_dack;
    idle(8);
    check("rst_no_ack", 64'((n_cack - b_cack) + (n_dack - b_dack)), 0);
    check("rst_outs", 64'({memaddr, cpurdata, dmardata}), 0);
    ack_dly = 2;
    tick(1, 0, 22'o3004, '0, 0, 0, '0, '0);
    idle(8);
    check("rst_after_ack", 64'(n_cack - b_cack), 1);
    check("rst_after_addr", 64'(last_mreq_addr), 64'(22'o3004));

    // Random traffic
    rand_mode = 1;
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 3) == 0, 1'($urandom), 22'($urandom), 16'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), 22'($urandom), 16'($urandom));
    rand_mode = 0; ack_dly = 1;
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
